// File: rtl/bsg_manycore_endpoint_ctrl_pkg.sv
// Shared types for the endpoint control stage: packet ops, config addresses and fence states.
// No logic here; latency and backpressure live in the modules that import it.
package bsg_manycore_endpoint_ctrl_pkg;

  typedef enum logic [1:0] {
    STORE = 2'd0,
    CFG   = 2'd1
  } ep_op_e;

  typedef enum logic [3:0] {
    FREEZE       = 4'd0,
    UNFREEZE     = 4'd1,
    ARB_CFG      = 4'd2,
    CREDIT_LIMIT = 4'd3
  } ep_cfg_addr_e;

  typedef enum logic {
    IDLE  = 1'b0,
    FENCE = 1'b1
  } fence_state_e;

  // Index width that stays >= 1 even for a single channel.
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_manycore_credit_chan.sv
// One outgoing credit channel: programmable limit, outstanding count, combinational avail.
// Updates land one cycle after launch/return/limit write; never stalls, flags underflow on err_o.
module bsg_manycore_credit_chan #(
  parameter int data_width_p      = 32,
  parameter int max_out_credits_p = 16,
  localparam int cred_w_lp        = $clog2(max_out_credits_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    launch_i,
  input  logic                    return_i,
  input  logic                    limit_v_i,
  input  logic [data_width_p-1:0] limit_data_i,
  output logic [cred_w_lp-1:0]    avail_o,
  output logic                    drained_o,
  output logic                    err_o
);

  localparam logic [cred_w_lp-1:0] max_lp = cred_w_lp'(max_out_credits_p);

  logic [cred_w_lp-1:0] limit_r;
  logic [cred_w_lp-1:0] outstanding_r;
  logic [cred_w_lp-1:0] limit_n;

  always_comb begin
    limit_n = max_lp;
    if (limit_data_i <= data_width_p'(max_out_credits_p))
      limit_n = limit_data_i[cred_w_lp-1:0];
  end

  // A simultaneous launch and return cancel, so only a lone return can underflow.
  assign err_o     = return_i & ~launch_i & (outstanding_r == '0);
  assign drained_o = (outstanding_r == '0);
  assign avail_o   = (limit_r > outstanding_r) ? (limit_r - outstanding_r) : '0;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      limit_r       <= max_lp;
      outstanding_r <= '0;
    end else begin
      if (limit_v_i)
        limit_r <= limit_n;
      if (launch_i && !return_i)
        outstanding_r <= outstanding_r + 1'b1;
      else if (return_i && !launch_i && (outstanding_r != '0))
        outstanding_r <= outstanding_r - 1'b1;
    end
  end

endmodule

// File: rtl/bsg_manycore_endpoint_credit_ctrl.sv
// Endpoint control: zero-latency store forwarding / config decode, per-channel credit gating, fence FSM.
// Stores stall on in_yumi_i; config packets dequeue same cycle; launches stall on credits, fence or out_ready_i.
module bsg_manycore_endpoint_credit_ctrl
  import bsg_manycore_endpoint_ctrl_pkg::*;
#(
  parameter int  data_width_p      = 32,
  parameter int  addr_width_p      = 32,
  parameter int  num_chan_p        = 2,
  parameter int  max_out_credits_p = 16,
  parameter logic freeze_init_p    = 1'b1,
  localparam int chan_w_lp         = safe_clog2(num_chan_p),
  localparam int cred_w_lp         = $clog2(max_out_credits_p + 1)
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,

  input  logic                            fifo_v_i,
  input  logic [1:0]                      fifo_op_i,
  input  logic [addr_width_p-1:0]         fifo_addr_i,
  input  logic [data_width_p-1:0]         fifo_data_i,
  input  logic [data_width_p/8-1:0]       fifo_mask_i,
  output logic                            fifo_yumi_o,

  output logic                            in_v_o,
  output logic [data_width_p-1:0]         in_data_o,
  output logic [addr_width_p-1:0]         in_addr_o,
  output logic [data_width_p/8-1:0]       in_mask_o,
  input  logic                            in_yumi_i,

  input  logic                            out_v_i,
  input  logic [chan_w_lp-1:0]            out_chan_i,
  input  logic                            out_ready_i,
  output logic                            out_ready_o,

  input  logic                            credit_v_i,
  input  logic [chan_w_lp-1:0]            credit_chan_i,
  output logic [num_chan_p*cred_w_lp-1:0] out_credits_o,

  input  logic                            fence_i,
  output logic                            fence_busy_o,

  input  logic                            in_fifo_full_i,
  output logic                            freeze_r_o,
  output logic                            reverse_arb_pr_o,
  output logic                            error_o
);

  localparam logic [chan_w_lp:0] num_chan_lp = num_chan_p[chan_w_lp:0];

  fence_state_e state_r, state_n;
  logic         arb_cfg_r;
  logic         fence_idle;

  // Input-side decode
  logic                 is_store, is_cfg;
  logic                 cfg_fire;
  logic [3:0]           cfg_addr;
  logic [chan_w_lp-1:0] cfg_chan;
  logic                 cfg_chan_legal;
  logic                 cfg_limit_fire;
  logic                 op_err, cfg_err;

  assign is_store = (fifo_op_i == STORE);
  assign is_cfg   = (fifo_op_i == CFG);
  assign cfg_fire = fifo_v_i & is_cfg;
  assign cfg_addr = fifo_addr_i[3:0];
  assign cfg_chan = fifo_addr_i[4 +: chan_w_lp];

  assign cfg_chan_legal = ({1'b0, cfg_chan} < num_chan_lp);
  assign cfg_limit_fire = cfg_fire & (cfg_addr == CREDIT_LIMIT) & cfg_chan_legal;

  assign op_err  = fifo_v_i & ~is_store & ~is_cfg;
  assign cfg_err = cfg_fire & ((cfg_addr > CREDIT_LIMIT) |
                               ((cfg_addr == CREDIT_LIMIT) & ~cfg_chan_legal));

  assign in_v_o      = fifo_v_i & is_store;
  assign in_data_o   = fifo_data_i;
  assign in_addr_o   = fifo_addr_i;
  assign in_mask_o   = fifo_mask_i;
  // Config and illegal packets never reach the core, so they are consumed on sight.
  assign fifo_yumi_o = is_store ? (fifo_v_i & in_yumi_i) : fifo_v_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      freeze_r_o <= freeze_init_p;
      arb_cfg_r  <= 1'b1;
    end else if (cfg_fire) begin
      case (cfg_addr)
        FREEZE:   freeze_r_o <= 1'b1;
        UNFREEZE: freeze_r_o <= 1'b0;
        ARB_CFG:  arb_cfg_r  <= fifo_data_i[0];
        default:  ;
      endcase
    end
  end

  assign reverse_arb_pr_o = arb_cfg_r & in_fifo_full_i;

  // Outgoing credit channels
  logic                 out_chan_legal, credit_chan_legal;
  logic                 launch;
  logic [cred_w_lp-1:0] avail    [num_chan_p];
  logic [num_chan_p-1:0] chan_drained;
  logic [num_chan_p-1:0] chan_err;
  logic [cred_w_lp-1:0] sel_avail;

  assign out_chan_legal    = ({1'b0, out_chan_i} < num_chan_lp);
  assign credit_chan_legal = ({1'b0, credit_chan_i} < num_chan_lp);

  always_comb begin
    sel_avail = '0;
    for (int c = 0; c < num_chan_p; c++)
      if (out_chan_i == chan_w_lp'(c))
        sel_avail = avail[c];
  end

  assign out_ready_o = out_ready_i & out_chan_legal & (sel_avail != '0)
                     & ~fence_i & (state_r == IDLE);
  assign launch      = out_v_i & out_ready_o;

  for (genvar c = 0; c < num_chan_p; c++) begin : g_chan
    bsg_manycore_credit_chan #(
      .data_width_p      (data_width_p),
      .max_out_credits_p (max_out_credits_p)
    ) chan (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .launch_i     (launch & (out_chan_i == chan_w_lp'(c))),
      .return_i     (credit_v_i & credit_chan_legal & (credit_chan_i == chan_w_lp'(c))),
      .limit_v_i    (cfg_limit_fire & (cfg_chan == chan_w_lp'(c))),
      .limit_data_i (fifo_data_i),
      .avail_o      (avail[c]),
      .drained_o    (chan_drained[c]),
      .err_o        (chan_err[c])
    );
    assign out_credits_o[c*cred_w_lp +: cred_w_lp] = avail[c];
  end

  // Sticky protocol error
  logic err_event;
  assign err_event = op_err | cfg_err | (|chan_err)
                   | (out_v_i & ~out_chan_legal)
                   | (credit_v_i & ~credit_chan_legal);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      error_o <= 1'b0;
    else if (err_event)
      error_o <= 1'b1;
  end

  // Fence FSM
  assign fence_idle = &chan_drained;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      state_r <= IDLE;
    else
      state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (fence_i)    state_n = FENCE;
      FENCE:   if (fence_idle) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    fence_busy_o = 1'b0;
    if (state_r == FENCE)
      fence_busy_o = 1'b1;
  end

endmodule

// File: tb/tb_bsg_manycore_endpoint_credit_ctrl.sv
// Directed bench for the endpoint credit control stage with default parameters (2 channels, 16 credits).
module tb_bsg_manycore_endpoint_credit_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        fifo_v_i;
  logic [1:0]  fifo_op_i;
  logic [31:0] fifo_addr_i;
  logic [31:0] fifo_data_i;
  logic [3:0]  fifo_mask_i;
  logic        fifo_yumi_o;
  logic        in_v_o;
  logic [31:0] in_data_o;
  logic [31:0] in_addr_o;
  logic [3:0]  in_mask_o;
  logic        in_yumi_i;
  logic        out_v_i;
  logic [0:0]  out_chan_i;
  logic        out_ready_i;
  logic        out_ready_o;
  logic        credit_v_i;
  logic [0:0]  credit_chan_i;
  logic [9:0]  out_credits_o;
  logic        fence_i;
  logic        fence_busy_o;
  logic        in_fifo_full_i;
  logic        freeze_r_o;
  logic        reverse_arb_pr_o;
  logic        error_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  bsg_manycore_endpoint_credit_ctrl dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .fifo_v_i         (fifo_v_i),
    .fifo_op_i        (fifo_op_i),
    .fifo_addr_i      (fifo_addr_i),
    .fifo_data_i      (fifo_data_i),
    .fifo_mask_i      (fifo_mask_i),
    .fifo_yumi_o      (fifo_yumi_o),
    .in_v_o           (in_v_o),
    .in_data_o        (in_data_o),
    .in_addr_o        (in_addr_o),
    .in_mask_o        (in_mask_o),
    .in_yumi_i        (in_yumi_i),
    .out_v_i          (out_v_i),
    .out_chan_i       (out_chan_i),
    .out_ready_i      (out_ready_i),
    .out_ready_o      (out_ready_o),
    .credit_v_i       (credit_v_i),
    .credit_chan_i    (credit_chan_i),
    .out_credits_o    (out_credits_o),
    .fence_i          (fence_i),
    .fence_busy_o     (fence_busy_o),
    .in_fifo_full_i   (in_fifo_full_i),
    .freeze_r_o       (freeze_r_o),
    .reverse_arb_pr_o (reverse_arb_pr_o),
    .error_o          (error_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are read well before the next one.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg(input logic [31:0] addr, input logic [31:0] data);
    fifo_v_i    = 1'b1;
    fifo_op_i   = 2'd1;
    fifo_addr_i = addr;
    fifo_data_i = data;
    tick();
    fifo_v_i    = 1'b0;
  endtask

  initial begin
    reset_n_i = 1'b0;
    fifo_v_i = 0; fifo_op_i = 0; fifo_addr_i = 0; fifo_data_i = 0; fifo_mask_i = 0;
    in_yumi_i = 0; out_v_i = 0; out_chan_i = 0; out_ready_i = 0;
    credit_v_i = 0; credit_chan_i = 0; fence_i = 0; in_fifo_full_i = 0;
    #12;
    chk("rst_freeze",  {31'd0, freeze_r_o},   32'd1);
    chk("rst_credits", {22'd0, out_credits_o}, 32'h210);
    chk("rst_busy",    {31'd0, fence_busy_o}, 32'd0);
    chk("rst_error",   {31'd0, error_o},      32'd0);
    reset_n_i = 1'b1;
    tick();

    // Unfreeze via config packet, consumed in the same cycle
    fifo_v_i = 1; fifo_op_i = 2'd1; fifo_addr_i = 32'h1;
    #1;
    chk("cfg_yumi", {31'd0, fifo_yumi_o}, 32'd1);
    chk("cfg_in_v", {31'd0, in_v_o},      32'd0);
    tick();
    fifo_v_i = 0;
    chk("unfreeze", {31'd0, freeze_r_o}, 32'd0);

    // Exhaust channel 0
    out_ready_i = 1; out_chan_i = 0; out_v_i = 1;
    #1;
    chk("rdy_c0_full", {31'd0, out_ready_o}, 32'd1);
    for (int i = 0; i < 16; i++) tick();
    out_v_i = 0;
    #1;
    chk("c0_avail_0", {27'd0, out_credits_o[4:0]}, 32'd0);
    chk("c0_not_rdy", {31'd0, out_ready_o},        32'd0);
    chk("c1_avail_16", {27'd0, out_credits_o[9:5]}, 32'd16);
    out_chan_i = 1;
    #1;
    chk("c1_rdy", {31'd0, out_ready_o}, 32'd1);
    out_ready_i = 0;
    #1;
    chk("net_not_rdy", {31'd0, out_ready_o}, 32'd0);
    out_ready_i = 1;

    // Channel 1 down to 5, then simultaneous launch and return
    out_v_i = 1;
    for (int i = 0; i < 11; i++) tick();
    chk("c1_avail_5", {27'd0, out_credits_o[9:5]}, 32'd5);
    credit_v_i = 1; credit_chan_i = 1;
    tick();
    out_v_i = 0;
    chk("c1_same_cycle", {27'd0, out_credits_o[9:5]}, 32'd5);
    for (int i = 0; i < 11; i++) tick();
    credit_v_i = 0;
    #1;
    chk("c1_back_16", {27'd0, out_credits_o[9:5]}, 32'd16);
    chk("no_err_yet", {31'd0, error_o},            32'd0);
    credit_v_i = 1;
    tick();
    credit_v_i = 0;
    chk("underflow_err", {31'd0, error_o}, 32'd1);

    // Reset mid-run clears error and counters, restores freeze
    reset_n_i = 0;
    #1;
    chk("rst2_error",   {31'd0, error_o},       32'd0);
    chk("rst2_freeze",  {31'd0, freeze_r_o},    32'd1);
    chk("rst2_credits", {22'd0, out_credits_o}, 32'h210);
    reset_n_i = 1;
    tick();

    // Lower chan 0 limit below outstanding
    out_chan_i = 0; out_v_i = 1;
    for (int i = 0; i < 6; i++) tick();
    out_v_i = 0;
    chk("c0_avail_10", {27'd0, out_credits_o[4:0]}, 32'd10);
    cfg(32'h03, 32'd4);
    #1;
    chk("c0_lim4_avail", {27'd0, out_credits_o[4:0]}, 32'd0);
    chk("c0_lim4_rdy",   {31'd0, out_ready_o},        32'd0);
    credit_v_i = 1; credit_chan_i = 0;
    for (int i = 0; i < 3; i++) tick();
    credit_v_i = 0;
    chk("c0_lim4_drain", {27'd0, out_credits_o[4:0]}, 32'd1);
    cfg(32'h13, 32'd7);
    chk("c1_lim7",  {27'd0, out_credits_o[9:5]}, 32'd7);
    cfg(32'h13, 32'd100);
    chk("c1_clamp", {27'd0, out_credits_o[9:5]}, 32'd16);
    cfg(32'h03, 32'd16);
    chk("c0_lim16", {27'd0, out_credits_o[4:0]}, 32'd13);

    // Fence with 3 outstanding on chan 0
    fence_i = 1;
    #1;
    chk("fence_in_blocks", {31'd0, out_ready_o}, 32'd0);
    tick();
    fence_i = 0;
    #1;
    chk("fence_busy",  {31'd0, fence_busy_o}, 32'd1);
    chk("fence_no_rdy", {31'd0, out_ready_o}, 32'd0);
    credit_v_i = 1; credit_chan_i = 0;
    tick(); tick();
    chk("fence_busy_2", {31'd0, fence_busy_o}, 32'd1);
    tick();
    credit_v_i = 0;
    chk("fence_busy_drained", {31'd0, fence_busy_o}, 32'd1);
    tick();
    chk("fence_done", {31'd0, fence_busy_o}, 32'd0);
    chk("fence_rdy",  {31'd0, out_ready_o},  32'd1);
    fence_i = 1;
    tick();
    fence_i = 0;
    chk("fence_empty_busy", {31'd0, fence_busy_o}, 32'd1);
    tick();
    chk("fence_empty_done", {31'd0, fence_busy_o}, 32'd0);
    chk("fence_no_err",     {31'd0, error_o},      32'd0);

    // Store held while the core stalls
    fifo_v_i = 1; fifo_op_i = 2'd0; fifo_addr_i = 32'h1234;
    fifo_data_i = 32'hdeadbeef; fifo_mask_i = 4'ha; in_yumi_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_v",    {31'd0, in_v_o},      32'd1);
      chk("st_yumi", {31'd0, fifo_yumi_o}, 32'd0);
      tick();
    end
    chk("st_data", in_data_o,          32'hdeadbeef);
    chk("st_addr", in_addr_o,          32'h1234);
    chk("st_mask", {28'd0, in_mask_o}, 32'ha);
    in_yumi_i = 1;
    #1;
    chk("st_yumi_go", {31'd0, fifo_yumi_o}, 32'd1);
    tick();
    fifo_v_i = 0; in_yumi_i = 0;

    // Arbitration config and freeze
    in_fifo_full_i = 1;
    #1;
    chk("rev_arb_on", {31'd0, reverse_arb_pr_o}, 32'd1);
    cfg(32'h2, 32'd0);
    chk("rev_arb_off", {31'd0, reverse_arb_pr_o}, 32'd0);
    cfg(32'h0, 32'd0);
    chk("refreeze", {31'd0, freeze_r_o}, 32'd1);
    chk("pre_bad_cfg_err", {31'd0, error_o}, 32'd0);
    cfg(32'h5, 32'd0);
    chk("bad_cfg_err", {31'd0, error_o}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
